pipeline_reg_execute: RTL
=========================

// Module: pipeline_reg_execute
// PURPOSE
//  Execute->writeback pipeline register that receives what the decode-stage register drives through
//  the ALU: ALU result, rd select and write enable. The register file consumes it at the writeback end.
//  - Valid/ready handshake on both sides.
//  - 2-entry skid buffer, so a writeback stall never drops an in-flight result.
//  - Synchronous flush squashes both entries on a branch/jump redirect.
// PARAMETERS
//  DATA_WIDTH  32  width of ALU result / writeback data
//  REG_AW      5   width of rd select (32 architectural registers)
//  STALL_CW    16  width of saturating stall-cycle counter
// PORTS
//  clk               in   1           rising-edge clock
//  rst_n             in   1           asynchronous active-low reset
//  flush             in   1           synchronous squash of all held entries
//  in_valid          in   1           upstream (ALU side) entry valid
//  in_ready          out  1           this block can accept an entry this cycle
//  write_enable_in   in   1           entry writes the register file
//  alu_result_in     in   DATA_WIDTH  ALU result
//  rd_sel_in         in   REG_AW      destination register
//  out_valid         out  1           writeback entry valid
//  out_ready         in   1           register file consumes the entry this cycle
//  write_enable_out  out  1           qualified write enable (see x0 rule)
//  wb_data_out       out  DATA_WIDTH  writeback data
//  rd_sel_out        out  REG_AW      writeback destination
//  stall_count       out  STALL_CW    cycles with out_valid && !out_ready, saturating
// BEHAVIOUR
//  - Reset (rst_n=0, async assert, sync-released on clk): all valids=0; data, rd, we and stall_count=0.
//    in_ready=1 while in reset and after reset.
//  - Storage:
//    - Output slot (O): drives the out_* ports.
//    - Skid slot (S): holds one entry when O is blocked.
//  - in_ready = !S.valid, a registered-state output with no combinational path from out_ready.
//  - Accept when in_valid && in_ready. Consume when out_valid && out_ready.
//  - Per-cycle update, with flush=0:
//    - O empty or consumed, S empty: an accepted entry goes to O. Latency is 1 cycle from accept to out_valid.
//    - O empty or consumed, S full: S moves to O. An accepted entry cannot occur (in_ready=0).
//    - O full and not consumed: an accepted entry goes to S, so in_ready drops next cycle.
//    - Simultaneous accept and consume with S empty: the new entry replaces O. This gives full throughput, 1 entry/cycle.
//  - Ordering is strictly FIFO; no entry is duplicated or lost.
//  - flush=1 has highest priority:
//    - O.valid and S.valid are cleared next edge.
//    - An entry accepted in the same cycle is discarded.
//    - out_valid=0 and in_ready=1 on the following cycle.
//    - stall_count is not cleared.
//  - x0 rule: write_enable_out = O.we && (rd_sel_out != 0). A stored rd=0 entry still handshakes normally.
//  - The out_* data ports hold their last value when out_valid=0. They are don't-care for the consumer.
//  - stall_count increments each cycle with out_valid && !out_ready and stops at all-ones. It is reset only by rst_n.
//  - Reset asserted mid-stall: both entries are lost and outputs return to reset values asynchronously.
// CONFIGURATION
//  FORWARD_EN defined:
//  - Adds outputs fwd_valid (1), fwd_rd (REG_AW) and fwd_data (DATA_WIDTH) for the decode-stage bypass mux.
//  - fwd_valid = O.valid && write_enable_out. fwd_rd and fwd_data mirror slot O.
//  - S is not forwarded; the hazard unit must stall while !in_ready.
//  FORWARD_EN undefined: these ports do not exist; no other behaviour changes.
// TESTING
//  1. Reset: rst_n=0 mid-stream -> out_valid=0, in_ready=1, stall_count=0, all data outputs 0, immediately.
//  2. Streaming with out_ready=1: 4 entries on consecutive cycles (x5=0x11..0x44)
//     -> appear 1 cycle later in order, one per cycle, in_ready stays 1.
//  3. Back-pressure:
//     - Send A=0xA (rd 3), then B=0xB (rd 4), with out_ready=0 -> A held on out, B in skid, in_ready=0.
//     - Then out_ready=1 -> A, then B, no loss; stall_count equals the stalled cycles.
//  4. Flush: O and S full, flush=1 with in_valid=1 (C=0xC) -> next cycle out_valid=0, in_ready=1, C never appears.
//  5. x0: we=1, rd=0, data 0xDEAD -> out_valid=1, write_enable_out=0. With FORWARD_EN defined, fwd_valid=0.
//  6. Saturation, with STALL_CW=4: 20 stalled cycles -> stall_count=15 and holds.

Source files
------------

// File: rtl/pipeline_reg_execute.sv
// Execute->writeback pipeline register with a 2-entry skid buffer, flush and stall counter.
// Define FORWARD_EN to add the fwd_valid/fwd_rd/fwd_data bypass outputs mirroring slot O.
module pipeline_reg_execute #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned STALL_CW   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  write_enable_in,
  input  logic [DATA_WIDTH-1:0] alu_result_in,
  input  logic [REG_AW-1:0]     rd_sel_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  write_enable_out,
  output logic [DATA_WIDTH-1:0] wb_data_out,
  output logic [REG_AW-1:0]     rd_sel_out,
`ifdef FORWARD_EN
  output logic                  fwd_valid,
  output logic [REG_AW-1:0]     fwd_rd,
  output logic [DATA_WIDTH-1:0] fwd_data,
`endif
  output logic [STALL_CW-1:0]   stall_count
);

  logic                  o_valid_q, o_valid_d;
  logic                  o_we_q, o_we_d;
  logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
  logic [REG_AW-1:0]     o_rd_q, o_rd_d;
  logic                  s_valid_q, s_valid_d;
  logic                  s_we_q, s_we_d;
  logic [DATA_WIDTH-1:0] s_data_q, s_data_d;
  logic [REG_AW-1:0]     s_rd_q, s_rd_d;
  logic [STALL_CW-1:0]   stall_q, stall_d;

  logic accept, consume;

  // in_ready comes from state only, so out_ready never reaches it combinationally.
  assign in_ready = !s_valid_q;
  assign accept   = in_valid && in_ready;
  assign consume  = o_valid_q && out_ready;

  always_comb begin
    o_valid_d = o_valid_q;
    o_we_d    = o_we_q;
    o_data_d  = o_data_q;
    o_rd_d    = o_rd_q;
    s_valid_d = s_valid_q;
    s_we_d    = s_we_q;
    s_data_d  = s_data_q;
    s_rd_d    = s_rd_q;
    if (flush) begin
      o_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!o_valid_q || consume) begin
      if (s_valid_q) begin
        o_valid_d = 1'b1;
        o_we_d    = s_we_q;
        o_data_d  = s_data_q;
        o_rd_d    = s_rd_q;
        s_valid_d = 1'b0;
      end else if (accept) begin
        o_valid_d = 1'b1;
        o_we_d    = write_enable_in;
        o_data_d  = alu_result_in;
        o_rd_d    = rd_sel_in;
      end else begin
        o_valid_d = 1'b0;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_we_d    = write_enable_in;
      s_data_d  = alu_result_in;
      s_rd_d    = rd_sel_in;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (o_valid_q && !out_ready && (stall_q != {STALL_CW{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid_q <= 1'b0;
      o_we_q    <= 1'b0;
      o_data_q  <= '0;
      o_rd_q    <= '0;
      s_valid_q <= 1'b0;
      s_we_q    <= 1'b0;
      s_data_q  <= '0;
      s_rd_q    <= '0;
      stall_q   <= '0;
    end else begin
      o_valid_q <= o_valid_d;
      o_we_q    <= o_we_d;
      o_data_q  <= o_data_d;
      o_rd_q    <= o_rd_d;
      s_valid_q <= s_valid_d;
      s_we_q    <= s_we_d;
      s_data_q  <= s_data_d;
      s_rd_q    <= s_rd_d;
      stall_q   <= stall_d;
    end
  end

  assign out_valid        = o_valid_q;
  // Writes to x0 are suppressed but the entry still handshakes.
  assign write_enable_out = o_we_q && (o_rd_q != '0);
  assign wb_data_out      = o_data_q;
  assign rd_sel_out       = o_rd_q;
  assign stall_count      = stall_q;

`ifdef FORWARD_EN
  assign fwd_valid = o_valid_q && write_enable_out;
  assign fwd_rd    = o_rd_q;
  assign fwd_data  = o_data_q;
`endif

endmodule
